// File: rtl/uart_result_tx.sv
// uart_result_tx: reports the template-match result to the host over UART.
// It takes the SAD control unit's result code and matching row, sends an
// ASCII message ("M" + three hex digits + CR LF, or "N" + CR LF), and then
// pulses send_complete so the control unit can return to IDLE.
// Optional feature macro: UART_PARITY_EN. When it is defined, each frame
// carries an even-parity bit between data bit 7 and the stop bit.
module uart_result_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] send_code,
    input  logic [8:0] match_row,
    output logic       tx,
    output logic       send_complete,
    output logic       busy
);

    localparam logic [1:0] CODE_OFF       = 2'd0;
    localparam logic [1:0] CODE_MATCH     = 2'd1;
    localparam logic [1:0] CODE_NOT_MATCH = 2'd2;

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    // NEXT names the between-frames decision. That decision is folded into
    // the STOP-end edge, so the register never actually holds NEXT.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        NEXT,
        WAIT_CLEAR
`ifdef UART_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [2:0]       byte_idx;
    logic [1:0]       code_lat;
    logic [8:0]       row_lat;
    logic [7:0]       cur_byte;
    logic             last_byte;
    logic             bit_end;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'b0000, n}) : (8'h37 + {4'b0000, n});
    endfunction

    assign bit_end = (baud_cnt == BIT_LAST);

    // Select the message byte for the current position from the latched request
    always_comb begin
        cur_byte  = 8'h0A;
        last_byte = 1'b0;
        if (code_lat == CODE_MATCH) begin
            last_byte = (byte_idx == 3'd5);
            case (byte_idx)
                3'd0:    cur_byte = 8'h4D;
                3'd1:    cur_byte = hex_ascii({3'b000, row_lat[8]});
                3'd2:    cur_byte = hex_ascii(row_lat[7:4]);
                3'd3:    cur_byte = hex_ascii(row_lat[3:0]);
                3'd4:    cur_byte = 8'h0D;
                default: cur_byte = 8'h0A;
            endcase
        end else begin
            last_byte = (byte_idx == 3'd2);
            case (byte_idx)
                3'd0:    cur_byte = 8'h4E;
                3'd1:    cur_byte = 8'h0D;
                default: cur_byte = 8'h0A;
            endcase
        end
    end

    // Message sequencer: baud timing, bit/byte stepping and the registered tx line
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            tx            <= 1'b1;
            send_complete <= 1'b0;
            busy          <= 1'b0;
            baud_cnt      <= '0;
            bit_idx       <= '0;
            byte_idx      <= '0;
            code_lat      <= CODE_OFF;
            row_lat       <= '0;
        end else begin
            send_complete <= 1'b0;
            case (state)
                IDLE: begin
                    if (send_code == CODE_MATCH || send_code == CODE_NOT_MATCH) begin
                        code_lat <= send_code;
                        row_lat  <= match_row;
                        byte_idx <= '0;
                        bit_idx  <= '0;
                        baud_cnt <= '0;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= cur_byte[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            tx    <= ^cur_byte;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (!last_byte) begin
                            byte_idx <= byte_idx + 3'd1;
                            bit_idx  <= '0;
                            tx       <= 1'b0;
                            state    <= START;
                        end else begin
                            send_complete <= 1'b1;
                            busy          <= 1'b0;
                            state         <= WAIT_CLEAR;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                NEXT: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                WAIT_CLEAR: begin
                    if (send_code == CODE_OFF) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_result_tx.sv
// tb_uart_result_tx: scoreboard bench for uart_result_tx with CLKS_PER_BIT=4.
// The stimulus pushes the expected message bytes and the completion cycles
// into queues. A UART receiver monitor and a send_complete monitor pop from
// those queues and compare against the DUT.
module tb_uart_result_tx;

    localparam int CPB = 4;
`ifdef UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] send_code = 2'd0;
    logic [8:0] match_row = 9'd0;
    logic       tx;
    logic       send_complete;
    logic       busy;

    int cycle    = 0;
    int checks   = 0;
    int failures = 0;

    logic [7:0] expBytes[$];
    int         expDone[$];

    uart_result_tx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .clock(clock),
        .reset(reset),
        .send_code(send_code),
        .match_row(match_row),
        .tx(tx),
        .send_complete(send_complete),
        .busy(busy)
    );

    // Free-running clock and an edge counter
    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // UART receiver monitor: samples each bit mid-way and checks framing and byte content
    logic       rxActive = 1'b0;
    int         rxOff    = 0;
    logic [7:0] rxByte   = 8'h00;

    always @(negedge clock) begin
        if (reset) begin
            rxActive = 1'b0;
        end else if (!rxActive) begin
            if (tx === 1'b0) begin
                rxActive = 1'b1;
                rxOff    = 0;
            end
        end else begin
            rxOff++;
            if (rxOff % CPB == CPB / 2) begin
                if (rxOff / CPB == 0) begin
                    checkOutput("start bit", int'(tx), 0);
                end else if (rxOff / CPB <= 8) begin
                    rxByte[rxOff / CPB - 1] = tx;
`ifdef UART_PARITY_EN
                end else if (rxOff / CPB == 9) begin
                    checkOutput("parity bit", int'(tx), int'(^rxByte));
`endif
                end else begin
                    checkOutput("stop bit", int'(tx), 1);
                    if (expBytes.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected byte: got 0x%0h, expected no traffic (cycle %0d)", rxByte, cycle);
                    end else begin
                        checkOutput("rx byte", int'(rxByte), int'(expBytes.pop_front()));
                    end
                    rxActive = 1'b0;
                end
            end
        end
    end

    // Completion monitor: every send_complete pulse must match a scheduled completion cycle
    always @(negedge clock) begin
        if (!reset && send_complete === 1'b1) begin
            if (expDone.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected send_complete: got pulse, expected none (cycle %0d)", cycle);
            end else begin
                checkOutput("send_complete cycle", cycle, expDone.pop_front());
            end
        end
    end

    // Issue a request at a negedge; acceptance happens at the next posedge
    task automatic applyStimulus(input logic [1:0] code, input logic [8:0] row,
                                 input int nbytes, input logic [47:0] bytes);
        for (int i = 0; i < nbytes; i++) begin
            expBytes.push_back(bytes[47 - 8*i -: 8]);
        end
        expDone.push_back(cycle + 1 + nbytes * FB * CPB);
        send_code = code;
        match_row = row;
    endtask

    // Wait for completion with a bound, then hold the code a while before clearing it
    task automatic waitComplete(input string name, input int holdCycles);
        logic done;
        logic busyOk;
        done   = 1'b0;
        busyOk = 1'b1;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clock);
            if (send_complete === 1'b1) done = 1'b1;
            else if (busy !== 1'b1) busyOk = 1'b0;
        end
        checkOutput({name, " completed"}, int'(done), 1);
        checkOutput({name, " busy held"}, int'(busyOk), 1);
        checkOutput({name, " busy at completion"}, int'(busy), 0);
        for (int k = 0; k < holdCycles; k++) begin
            @(negedge clock);
            checkOutput({name, " busy after completion"}, int'(busy), 0);
            checkOutput({name, " tx idle after completion"}, int'(tx), 1);
        end
        send_code = 2'd0;
        repeat (3) @(negedge clock);
    endtask

    // Main directed sequence
    initial begin
        repeat (3) @(negedge clock);
        checkOutput("reset tx", int'(tx), 1);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset send_complete", int'(send_complete), 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        $display("[TB] MATCH row 0x17B");
        applyStimulus(2'd1, 9'h17B, 6, {8'h4D, 8'h31, 8'h37, 8'h42, 8'h0D, 8'h0A});
        waitComplete("match 17B", 1);

        $display("[TB] NOT_MATCH, row ignored");
        applyStimulus(2'd2, 9'h155, 3, {8'h4E, 8'h0D, 8'h0A, 24'h0});
        waitComplete("not_match", 1);

        $display("[TB] MATCH row 0x0FF, code held after completion");
        applyStimulus(2'd1, 9'h0FF, 6, {8'h4D, 8'h30, 8'h46, 8'h46, 8'h0D, 8'h0A});
        waitComplete("match 0FF hold", 3);
        applyStimulus(2'd2, 9'h000, 3, {8'h4E, 8'h0D, 8'h0A, 24'h0});
        waitComplete("not_match after hold", 1);

        $display("[TB] invalid code then MATCH row 0x0A5");
        match_row = 9'h0A5;
        send_code = 2'd3;
        repeat (5) @(negedge clock);
        checkOutput("code 3 busy", int'(busy), 0);
        checkOutput("code 3 tx", int'(tx), 1);
        applyStimulus(2'd1, 9'h0A5, 6, {8'h4D, 8'h30, 8'h41, 8'h35, 8'h0D, 8'h0A});
        repeat (10) @(negedge clock);
        match_row = 9'h1FF;
        waitComplete("match 0A5", 1);

        $display("[TB] reset mid-message");
        applyStimulus(2'd1, 9'h17B, 6, {8'h4D, 8'h31, 8'h37, 8'h42, 8'h0D, 8'h0A});
        repeat (50) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("abort tx", int'(tx), 1);
        checkOutput("abort busy", int'(busy), 0);
        checkOutput("abort send_complete", int'(send_complete), 0);
        expBytes.delete();
        expDone.delete();
        send_code = 2'd0;
        @(negedge clock);
        reset = 1'b0;
        repeat (100) @(negedge clock);
        checkOutput("after abort busy", int'(busy), 0);
        checkOutput("after abort tx", int'(tx), 1);
        applyStimulus(2'd2, 9'h000, 3, {8'h4E, 8'h0D, 8'h0A, 24'h0});
        waitComplete("not_match after abort", 1);

        repeat (20) @(negedge clock);
        checkOutput("leftover bytes", expBytes.size(), 0);
        checkOutput("leftover completions", expDone.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    // Watchdog so the run can never hang
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
